// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mult_sign_mag.sv
// Splits an operand into an unsigned magnitude and a sign bit; the magnitude
// keeps the full width so the most negative value stays representable.
module mult_sign_mag #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] val,
    input  logic         signed_mode,
    output logic [W-1:0] mag,
    output logic         neg
);

    always_comb begin
        neg = signed_mode & val[W-1];
        mag = neg ? -val : val;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned per transaction,
// with valid/ready handshakes on operand and product sides.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned A_W = 8,
    parameter int unsigned B_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out_p,
    output logic                 busy
);

    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned CNT_W = clog2_w(B_W);

    state_t            state_q, state_d;
    logic [A_W-1:0]    mag_a_q, mag_a_d;
    logic              neg_q, neg_d;
    logic [P_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [P_W-1:0]    out_p_q, out_p_d;

    logic [A_W-1:0]    in_mag_a;
    logic [B_W-1:0]    in_mag_b;
    logic              in_neg_a, in_neg_b;
    logic              last;
    logic [A_W:0]      sum;
    logic [P_W-1:0]    acc_step;

    mult_sign_mag #(.W(A_W)) u_sm_a (
        .val(in_a), .signed_mode(in_signed), .mag(in_mag_a), .neg(in_neg_a)
    );
    mult_sign_mag #(.W(B_W)) u_sm_b (
        .val(in_b), .signed_mode(in_signed), .mag(in_mag_b), .neg(in_neg_b)
    );

    // Multiplier magnitude rides in the low half of the accumulator and is
    // consumed one bit per shift while the product grows in from the top.
    always_comb begin
        last     = (cnt_q == CNT_W'(B_W - 1));
        sum      = {1'b0, acc_q[P_W-1:B_W]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        acc_step = {sum, acc_q[B_W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_a_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_p_q <= out_p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        mag_a_d = mag_a_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_p_d = out_p_q;
        if (state_q == IDLE && in_valid) begin
            mag_a_d = in_mag_a;
            neg_d   = in_neg_a ^ in_neg_b;
            acc_d   = {{A_W{1'b0}}, in_mag_b};
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) out_p_d = neg_q ? -acc_step : acc_step;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == BUSY);
        out_valid = (state_q == DONE);
        out_p     = out_p_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: default 8x4 instance plus a 16x16 sweep instance.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [7:0]  in_a;
    logic [3:0]  in_b;
    logic [11:0] out_p;

    logic        w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready, w_busy;
    logic [15:0] w_in_a, w_in_b;
    logic [31:0] w_out_p;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.A_W(8), .B_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy)
    );

    seq_multiplier #(.A_W(16), .B_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_signed(w_in_signed), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_p(w_out_p), .busy(w_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair on the 8x4 unit, check latency and product,
    // optionally hand the result off.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic s, input logic [11:0] exp, input bit handoff);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 4'($urandom); in_signed = ~s;
        check({tag, " busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " product"}, 64'(out_p), 64'(exp));
        if (handoff) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, " handoff"}, {62'd0, out_valid, in_ready}, 64'd1);
        end
    endtask

    task automatic run_wide(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        longint pa, pb;
        logic [31:0] exp;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        exp = 32'(pa * pb);
        n = 0;
        while (!w_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        w_in_a = a; w_in_b = b; w_in_signed = s; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 60) begin @(posedge clk); #1; n++; end
        check("wide latency", 64'(n), 64'd16);
        check("wide product", 64'(w_out_p), 64'(exp));
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] held;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_signed = 1'b0; w_out_ready = 1'b0;
        #12;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy",      64'(busy),      64'd0);
        check("reset out_p",     64'(out_p),     64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("unsigned max",   8'hFF, 4'hF, 1'b0, 12'hEF1, 1'b1);
        run_op("signed extreme", 8'h80, 4'h8, 1'b1, 12'h400, 1'b1);
        run_op("signed mixed",   8'h80, 4'h7, 1'b1, 12'hC80, 1'b1);
        run_op("signed -1*-1",   8'hFF, 4'hF, 1'b1, 12'h001, 1'b1);
        run_op("unsigned same",  8'hFF, 4'hF, 1'b0, 12'hEF1, 1'b1);
        run_op("zero signed",    8'h00, 4'h9, 1'b1, 12'h000, 1'b1);
        run_op("neg times zero", 8'h85, 4'h0, 1'b1, 12'h000, 1'b1);

        // Backpressure: product must hold and new operands must be ignored.
        run_op("backpressure", 8'd100, 4'd12, 1'b0, 12'd1200, 1'b0);
        held = out_p;
        in_a = 8'd2; in_b = 4'd2; in_signed = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp out_p stable", 64'(out_p), 64'(held));
            check("bp status", {61'd0, out_valid, in_ready, busy}, 64'b100);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", {62'd0, out_valid, in_ready}, 64'b01);
        run_op("after bp 3*5", 8'd3, 4'd5, 1'b0, 12'd15, 1'b1);

        // Reset two cycles into an operation aborts it asynchronously.
        in_a = 8'hAB; in_b = 4'hC; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset status", {61'd0, out_valid, in_ready, busy}, 64'b010);
        check("async reset out_p", 64'(out_p), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
        run_op("after reset 7*9", 8'd7, 4'd9, 1'b0, 12'd63, 1'b1);

        run_wide(16'h8000, 16'h8000, 1'b1);
        run_wide(16'hFFFF, 16'hFFFF, 1'b0);
        run_wide(16'hFFFF, 16'hFFFF, 1'b1);
        run_wide(16'h8000, 16'h7FFF, 1'b1);
        run_wide(16'h0000, 16'h8000, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run_wide(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier; successor to the team's fixed 8x4 combinational unsigned multiplier.
- Computes the A_W x B_W product over B_W cycles, one multiplier bit per cycle.
- Supports a per-transaction signed (two's complement) or unsigned mode.
- Sits between producer and consumer logic with valid/ready handshakes on both sides, so arithmetic datapaths can trade latency for area.

Parameters:
A_W, 8, multiplicand width in bits (>=2)
B_W, 4, multiplier width in bits (>=2); also the iteration count
P_W, A_W+B_W, product width (derived localparam; not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in_a  input  A_W  multiplicand
in_b  input  B_W  multiplier
in_signed  input  1  1: operands and result two's complement; 0: unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  P_W  product
busy  output  1  iteration in progress

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; out_p=0; all internal registers cleared.
- Reset asserted mid-operation aborts immediately; the partial product is discarded and no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T:
    - latch |a| and |b| as magnitudes; negation is applied only if in_signed=1 and the operand MSB=1, and the magnitude is held in A_W/B_W bits unsigned, so -2^(A_W-1) is representable.
    - latch neg = in_signed & (a_msb ^ b_msb); clear the accumulator and iteration counter; go to BUSY.
  - BUSY: busy=1, in_ready=0. Each edge adds (mag_a if current multiplier LSB=1) to the upper accumulator, then shifts right one bit.
    - The counter runs 0..B_W-1.
    - On the last iteration (edge T+B_W), out_p is loaded with the accumulator, or its two's complement negation if neg=1, and the state goes to DONE.
  - DONE: out_valid=1, out_p held stable. On out_valid&out_ready go to IDLE with out_valid=0 on the next edge.
- Latency: out_valid rises after edge T+B_W (B_W cycles after acceptance).
- Throughput: one product per B_W+2 cycles minimum (accept, B_W iterations, handoff).
- in_ready is low in BUSY and DONE; in_valid there is ignored, and no operands are latched.
- out_ready held low backpressures indefinitely; out_p must not change while out_valid=1.
- Inputs are sampled only at the accept edge; changes during BUSY have no effect.
- Results:
  - Unsigned result = a*b exactly in P_W bits (no overflow possible).
  - Signed result = a*b exactly in P_W-bit two's complement. The extreme (-2^(A_W-1))*(-2^(B_W-1)) = 2^(P_W-2) fits.
- Zero operand: still takes the full B_W cycles; result is 0 (never negative zero artefacts, since the negation of 0 is 0).
- The counter width is clog2(B_W).

Decomposition:
- Shared package (mult_pkg): state encoding constants (IDLE, BUSY, DONE) and a clog2-style width function.
- One natural sub-module: mult_sign_mag. It is combinational and produces abs value + sign bit given width and signed flag. It is instantiated twice at input, plus a conditional negate at output.
- The control FSM and accumulator stay in seq_multiplier.

Test Plan:
- Unsigned max, A_W=8, B_W=4: a=255, b=15, signed=0 -> out_valid exactly 4 cycles after accept; out_p=3825 (0xEF1).
- Signed extreme: a=0x80 (-128), b=0x8 (-8), signed=1 -> out_p=1024 (0x400). Then a=0x80, b=0x7 -> out_p=-896 (0xC80).
- Mode contrast: a=0xFF, b=0xF, signed=1 -> 0x001; the same operands with signed=0 -> 0xEF1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_p stable, in_ready=0, new in_valid ignored. Then release -> IDLE; next op 3*5 -> 15.
- Reset mid-BUSY: assert rst_n=0 two cycles after accept -> out_valid=0 and in_ready=1 immediately (asynchronously). After release, the next op 7*9 -> 63 with no stale result.
- Parameter sweep (A_W=16, B_W=16): random signed/unsigned 1000 ops versus a reference model -> all match; latency always 16.
